// File: rtl/servant_wb_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : servant_wb_sched_if
// Description : Wishbone bus bundle shared by the scheduler's three ports.
//               master modport drives the request side, slave modport answers.
//               adr/dat/sel/we/cyc : request (master -> slave)
//               rdt/ack            : response (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface servant_wb_sched_if #(
  parameter int AW = 32
);
  logic [AW-1:0] adr;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic [31:0]   rdt;
  logic          ack;

  modport master (output adr, dat, sel, we, cyc, input  rdt, ack);
  modport slave  (input  adr, dat, sel, we, cyc, output rdt, ack);
endinterface
`default_nettype wire

// File: rtl/servant_wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : servant_wb_watchdog
// Description : Loadable down-counter bounding how long a granted transaction
//               may wait for its acknowledge.
//               clk_i     : clock
//               rst_i     : synchronous active-high reset (count -> 0)
//               load_i    : reload the counter with TIMEOUT
//               en_i      : count down one step (saturates at zero)
//               expired_o : counter has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module servant_wb_watchdog #(
  parameter  int TIMEOUT = 255,
  localparam int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = W'(TIMEOUT);
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);
endmodule
`default_nettype wire

// File: rtl/servant_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : servant_wb_sched
// Description : Round-robin scheduler sharing one Wishbone RAM port between
//               the SERV instruction bus and data bus, with a per-transaction
//               watchdog and a sticky timeout flag.
//               i_wb_clk  : clock
//               i_wb_rst  : synchronous active-high reset
//               wb_ibus   : instruction master (read-only fetches)
//               wb_dbus   : data master
//               wb_mem    : shared slave port
//               o_timeout : sticky, set when a transaction was force-ended
// Revision    : 1.0 - initial release
// ============================================================================
module servant_wb_sched #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               i_wb_clk,
  input  logic               i_wb_rst,
  servant_wb_sched_if.slave  wb_ibus,
  servant_wb_sched_if.slave  wb_dbus,
  servant_wb_sched_if.master wb_mem,
  output logic               o_timeout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_I = 2'd1;
  localparam logic [1:0] S_GNT_D = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0] state_q, state_d;
  logic       last_d_q, last_d_d;    // 1: dbus completed most recently
  logic       timeout_q, timeout_d;

  logic        w_gnt_i, w_gnt_d, w_sel_cyc, w_done, w_expired;
  logic [31:0] w_rdt;
  logic        w_unused;

  // Ibus is a read-only fetch port; its write-side fields are never used.
  assign w_unused = ^{wb_ibus.dat, wb_ibus.sel, wb_ibus.we};

  // Grants are masked by reset so every output is quiet while reset is held.
  assign w_gnt_i   = (state_q == S_GNT_I) && !i_wb_rst;
  assign w_gnt_d   = (state_q == S_GNT_D) && !i_wb_rst;
  assign w_sel_cyc = (w_gnt_i && wb_ibus.cyc) || (w_gnt_d && wb_dbus.cyc);
  // Completion is either a real slave ack or the watchdog running out.
  assign w_done    = w_sel_cyc && (wb_mem.ack || w_expired);
  // A forced completion returns zero data.
  assign w_rdt     = wb_mem.ack ? wb_mem.rdt : 32'h0;

  servant_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (i_wb_clk),
    .rst_i     (i_wb_rst),
    .load_i    (state_q == S_IDLE),
    .en_i      ((w_gnt_i || w_gnt_d) && !wb_mem.ack),
    .expired_o (w_expired)
  );

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (wb_ibus.cyc && wb_dbus.cyc) begin
          state_d = last_d_q ? S_GNT_I : S_GNT_D;
        end else if (wb_ibus.cyc) begin
          state_d = S_GNT_I;
        end else if (wb_dbus.cyc) begin
          state_d = S_GNT_D;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (!w_sel_cyc) begin
          // Master abandoned the cycle: release without ack or timeout.
          state_d = S_GAP;
        end else if (w_done) begin
          state_d  = S_GAP;
          last_d_d = (state_q == S_GNT_D);
          if (!wb_mem.ack) begin
            timeout_d = 1'b1;
          end
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q   <= S_IDLE;
      last_d_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      timeout_q <= timeout_d;
    end
  end

  assign wb_ibus.ack = w_done && w_gnt_i;
  assign wb_ibus.rdt = (w_done && w_gnt_i) ? w_rdt : 32'h0;
  assign wb_dbus.ack = w_done && w_gnt_d;
  assign wb_dbus.rdt = (w_done && w_gnt_d) ? w_rdt : 32'h0;

  assign wb_mem.cyc = w_sel_cyc;
  assign wb_mem.adr = w_gnt_i ? wb_ibus.adr : (w_gnt_d ? wb_dbus.adr : '0);
  assign wb_mem.dat = w_gnt_d ? wb_dbus.dat : 32'h0;
  assign wb_mem.sel = w_gnt_i ? 4'hF : (w_gnt_d ? wb_dbus.sel : 4'h0);
  assign wb_mem.we  = w_gnt_d && wb_dbus.we;

  assign o_timeout = timeout_q && !i_wb_rst;
endmodule
`default_nettype wire

// File: tb/tb_servant_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_servant_wb_sched
// Description : Directed self-checking bench for servant_wb_sched with a
//               4-cycle watchdog and a scripted or auto-acking RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_wb_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_auto = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdt = 32'h0;
  logic        o_timeout;
  int          vectors = 0;
  int          errors  = 0;

  servant_wb_sched_if #(.AW(32)) ibus_if ();
  servant_wb_sched_if #(.AW(32)) dbus_if ();
  servant_wb_sched_if #(.AW(32)) mem_if ();

  // Auto mode: zero-wait slave returning an address-derived word.
  assign mem_if.ack = slave_auto ? mem_if.cyc : man_ack;
  assign mem_if.rdt = slave_auto ? (mem_if.adr ^ 32'hA5A5_0000) : man_rdt;

  servant_wb_sched #(.AW(32), .TIMEOUT(4)) dut (
    .i_wb_clk  (clk),
    .i_wb_rst  (rst),
    .wb_ibus   (ibus_if),
    .wb_dbus   (dbus_if),
    .wb_mem    (mem_if),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ibus_if.cyc = 1'b0;
    dbus_if.cyc = 1'b0;
    man_ack     = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ibus_if.adr = '0; ibus_if.dat = '0; ibus_if.sel = '0; ibus_if.we = 1'b0; ibus_if.cyc = 1'b0;
    dbus_if.adr = '0; dbus_if.dat = '0; dbus_if.sel = '0; dbus_if.we = 1'b0; dbus_if.cyc = 1'b0;
    step(); step();
    man_ack = 1'b1; man_rdt = 32'h1111_2222; ibus_if.cyc = 1'b1;
    #1;
    vectors++; if (mem_if.cyc !== 1'b0) begin errors++; $display("FAIL reset_mem_cyc: got %b want 0", mem_if.cyc); end
    vectors++; if (ibus_if.ack !== 1'b0) begin errors++; $display("FAIL reset_ibus_ack: got %b want 0", ibus_if.ack); end
    vectors++; if (dbus_if.ack !== 1'b0) begin errors++; $display("FAIL reset_dbus_ack: got %b want 0", dbus_if.ack); end
    vectors++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
    step();
    rst = 1'b0; ibus_if.cyc = 1'b0; man_ack = 1'b0;
    step();
  endtask

  task automatic test_lone_fetch();
    ibus_if.adr = 32'h100; ibus_if.cyc = 1'b1;
    #1;
    vectors++; if (mem_if.cyc !== 1'b0) begin errors++; $display("FAIL fetch_latency0: got %b want 0", mem_if.cyc); end
    step(); #1;
    vectors++; if (mem_if.cyc !== 1'b1) begin errors++; $display("FAIL fetch_mem_cyc: got %b want 1", mem_if.cyc); end
    vectors++; if (mem_if.adr !== 32'h100) begin errors++; $display("FAIL fetch_mem_adr: got %h want 00000100", mem_if.adr); end
    vectors++; if ({mem_if.we, mem_if.sel} !== 5'b0_1111) begin errors++; $display("FAIL fetch_we_sel: got %b want 01111", {mem_if.we, mem_if.sel}); end
    vectors++; if (ibus_if.ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack: got %b want 0", ibus_if.ack); end
    step();
    man_ack = 1'b1; man_rdt = 32'h1234_5678;
    #1;
    vectors++; if (ibus_if.ack !== 1'b1) begin errors++; $display("FAIL fetch_ack: got %b want 1", ibus_if.ack); end
    vectors++; if (ibus_if.rdt !== 32'h1234_5678) begin errors++; $display("FAIL fetch_rdt: got %h want 12345678", ibus_if.rdt); end
    step();
    man_ack = 1'b0; ibus_if.cyc = 1'b0;
    #1;
    vectors++; if ({mem_if.cyc, ibus_if.ack} !== 2'b00) begin errors++; $display("FAIL fetch_gap: got %b want 00", {mem_if.cyc, ibus_if.ack}); end
    step();
  endtask

  task automatic test_simultaneous();
    rst = 1'b1; step(); rst = 1'b0; step();
    ibus_if.adr = 32'h100; ibus_if.cyc = 1'b1;
    dbus_if.adr = 32'h2000; dbus_if.dat = 32'hDEAD_BEEF; dbus_if.sel = 4'b0011; dbus_if.we = 1'b1; dbus_if.cyc = 1'b1;
    step();
    man_ack = 1'b1; man_rdt = 32'h0;
    #1;
    vectors++; if (mem_if.adr !== 32'h2000) begin errors++; $display("FAIL tie_mem_adr: got %h want 00002000", mem_if.adr); end
    vectors++; if (mem_if.dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tie_mem_dat: got %h want deadbeef", mem_if.dat); end
    vectors++; if ({mem_if.cyc, mem_if.we, mem_if.sel} !== 6'b11_0011) begin errors++; $display("FAIL tie_cyc_we_sel: got %b want 110011", {mem_if.cyc, mem_if.we, mem_if.sel}); end
    vectors++; if ({dbus_if.ack, ibus_if.ack} !== 2'b10) begin errors++; $display("FAIL tie_acks: got %b want 10", {dbus_if.ack, ibus_if.ack}); end
    step();
    man_ack = 1'b0; dbus_if.cyc = 1'b0; dbus_if.we = 1'b0;
    #1;
    vectors++; if ({mem_if.cyc, dbus_if.ack, ibus_if.ack} !== 3'b000) begin errors++; $display("FAIL tie_gap: got %b want 000", {mem_if.cyc, dbus_if.ack, ibus_if.ack}); end
    step(); #1;
    vectors++; if (mem_if.cyc !== 1'b0) begin errors++; $display("FAIL tie_idle: got %b want 0", mem_if.cyc); end
    step();
    man_ack = 1'b1; man_rdt = 32'hCAFE_F00D;
    #1;
    vectors++; if ({mem_if.adr, mem_if.we, mem_if.sel} !== {32'h100, 1'b0, 4'hF}) begin errors++; $display("FAIL tie_second_ibus: got %h/%b/%h want 00000100/0/f", mem_if.adr, mem_if.we, mem_if.sel); end
    vectors++; if (ibus_if.rdt !== 32'hCAFE_F00D) begin errors++; $display("FAIL tie_second_rdt: got %h want cafef00d", ibus_if.rdt); end
    step();
    idle(2);
  endtask

  task automatic test_back_to_back();
    int   n    = 0;
    int   lows = 0;
    logic exp_d;
    slave_auto = 1'b1;
    ibus_if.adr = 32'h40; dbus_if.adr = 32'h80; dbus_if.sel = 4'hF; dbus_if.we = 1'b0;
    ibus_if.cyc = 1'b1; dbus_if.cyc = 1'b1;
    for (int c = 0; c < 60 && n < 8; c++) begin
      step(); #1;
      if (mem_if.cyc) begin
        exp_d = (n % 2 == 0);
        vectors++; if (mem_if.adr !== (exp_d ? 32'h80 : 32'h40)) begin errors++; $display("FAIL b2b_order[%0d]: got adr %h want %h", n, mem_if.adr, exp_d ? 32'h80 : 32'h40); end
        vectors++; if ({dbus_if.ack, ibus_if.ack} !== {exp_d, ~exp_d}) begin errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", n, {dbus_if.ack, ibus_if.ack}, {exp_d, ~exp_d}); end
        vectors++; if ((exp_d ? dbus_if.rdt : ibus_if.rdt) !== (exp_d ? 32'hA5A5_0080 : 32'hA5A5_0040)) begin errors++; $display("FAIL b2b_rdt[%0d]: got %h want %h", n, exp_d ? dbus_if.rdt : ibus_if.rdt, exp_d ? 32'hA5A5_0080 : 32'hA5A5_0040); end
        if (n > 0) begin
          vectors++; if (lows !== 2) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d idle cycles want 2", n, lows); end
        end
        n++;
        lows = 0;
      end else begin
        lows++;
      end
    end
    vectors++; if (n !== 8) begin errors++; $display("FAIL b2b_count: got %0d transactions want 8", n); end
    slave_auto = 1'b0;
    idle(3);
  endtask

  task automatic test_timeout();
    dbus_if.adr = 32'h300; dbus_if.we = 1'b0; dbus_if.sel = 4'hF; dbus_if.cyc = 1'b1;
    man_ack = 1'b0; man_rdt = 32'h5555_5555;
    for (int k = 1; k <= 5; k++) begin
      step(); #1;
      vectors++; if (dbus_if.ack !== (k == 5)) begin errors++; $display("FAIL to_ack[cycle %0d]: got %b want %b", k, dbus_if.ack, k == 5); end
    end
    vectors++; if ({mem_if.cyc, dbus_if.rdt} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_forced: got cyc %b rdt %h want cyc 1 rdt 00000000", mem_if.cyc, dbus_if.rdt); end
    vectors++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL to_flag_early: got %b want 0", o_timeout); end
    step();
    dbus_if.cyc = 1'b0;
    #1;
    vectors++; if ({o_timeout, mem_if.cyc, dbus_if.ack} !== 3'b100) begin errors++; $display("FAIL to_after: got %b want 100", {o_timeout, mem_if.cyc, dbus_if.ack}); end
    step();
    ibus_if.adr = 32'h104; ibus_if.cyc = 1'b1;
    step();
    man_ack = 1'b1; man_rdt = 32'h0BAD_F00D;
    #1;
    vectors++; if ({o_timeout, ibus_if.ack, ibus_if.rdt} !== {2'b11, 32'h0BAD_F00D}) begin errors++; $display("FAIL to_sticky: got %b/%b/%h want 1/1/0badf00d", o_timeout, ibus_if.ack, ibus_if.rdt); end
    step();
    idle(2);
  endtask

  task automatic test_spurious_ack();
    man_ack = 1'b1; man_rdt = 32'hFFFF_FFFF;
    #1;
    vectors++; if ({ibus_if.ack, dbus_if.ack} !== 2'b00) begin errors++; $display("FAIL spur_idle: got %b want 00", {ibus_if.ack, dbus_if.ack}); end
    step();
    man_ack = 1'b0; ibus_if.adr = 32'h108; ibus_if.cyc = 1'b1;
    step();
    man_ack = 1'b1;
    step();
    ibus_if.cyc = 1'b0;
    #1;
    vectors++; if ({mem_if.cyc, ibus_if.ack, dbus_if.ack} !== 3'b000) begin errors++; $display("FAIL spur_gap: got %b want 000", {mem_if.cyc, ibus_if.ack, dbus_if.ack}); end
    step();
    dbus_if.adr = 32'h400; dbus_if.we = 1'b0; dbus_if.cyc = 1'b1;
    #1;
    vectors++; if ({mem_if.cyc, ibus_if.ack, dbus_if.ack} !== 3'b000) begin errors++; $display("FAIL spur_idle2: got %b want 000", {mem_if.cyc, ibus_if.ack, dbus_if.ack}); end
    step();
    man_ack = 1'b0;
    #1;
    vectors++; if ({mem_if.cyc, mem_if.adr} !== {1'b1, 32'h400}) begin errors++; $display("FAIL spur_regrant: got %b/%h want 1/00000400", mem_if.cyc, mem_if.adr); end
    step();
    man_ack = 1'b1;
    step();
    idle(2);
  endtask

  task automatic test_reset_mid();
    ibus_if.adr = 32'h200; ibus_if.cyc = 1'b1;
    step();
    man_ack = 1'b0;
    #1;
    vectors++; if (mem_if.cyc !== 1'b1) begin errors++; $display("FAIL rmid_granted: got %b want 1", mem_if.cyc); end
    rst = 1'b1;
    step();
    rst = 1'b0; man_ack = 1'b1; man_rdt = 32'h0000_600D;
    #1;
    vectors++; if ({mem_if.cyc, ibus_if.ack, o_timeout} !== 3'b000) begin errors++; $display("FAIL rmid_after: got %b want 000", {mem_if.cyc, ibus_if.ack, o_timeout}); end
    step(); #1;
    vectors++; if ({mem_if.cyc, ibus_if.ack, ibus_if.rdt} !== {2'b11, 32'h0000_600D}) begin errors++; $display("FAIL rmid_regrant: got %b/%b/%h want 1/1/0000600d", mem_if.cyc, ibus_if.ack, ibus_if.rdt); end
    step();
    idle(2);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_spurious_ack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
